// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and constants for the serial shift sequencer.
//   state_e   : controller FSM states
//   Sel*      : universal shift register mode select (s input)
//   shift_sel : select code for a shift event in the given direction
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [1:0] SelHold  = 2'b00;
  localparam logic [1:0] SelRight = 2'b01;
  localparam logic [1:0] SelLeft  = 2'b10;
  localparam logic [1:0] SelLoad  = 2'b11;

  // dir = 0 sends LSB first (shift right), dir = 1 sends MSB first (shift left).
  function automatic logic [1:0] shift_sel(input logic dir);
    return dir ? SelLeft : SelRight;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Bus between the shift sequencer and its producer/consumer and serial pins.
//   in_valid/in_ready/in_data/dir : parallel word in (dir sampled with the word)
//   out_valid/out_ready/out_data  : received word out
//   abort                         : synchronous cancel
//   serial_in/serial_out          : serial pin pair
//   shift_tick/busy               : status
// slave = controller side, master = producer/consumer side.
interface shift_seq_ctrl_if #(
  parameter int unsigned N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         dir;
  logic         abort;
  logic         serial_in;
  logic         serial_out;
  logic         shift_tick;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  modport slave (
    input  in_valid, in_data, dir, abort, serial_in, out_ready,
    output in_ready, serial_out, shift_tick, busy, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, dir, abort, serial_in, out_ready,
    input  in_ready, serial_out, shift_tick, busy, out_valid, out_data
  );
endinterface

// File: rtl/shift_seq_ctrl_univ_shift_reg.sv
// N-bit universal shift register (datapath of the shift sequencer).
//   clk_i, rst_ni : clock, async active-low clear
//   s_i           : 00 hold, 01 shift right (msb_in_i enters), 10 shift left
//                   (lsb_in_i enters), 11 parallel load of d_i
//   q_o           : register contents
module univ_shift_reg
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [1:0]   s_i,
  input  logic [N-1:0] d_i,
  input  logic         msb_in_i,
  input  logic         lsb_in_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    unique case (s_i)
      SelHold:  q_d = q_q;
      SelRight: q_d = {msb_in_i, q_q[N-1:1]};
      SelLeft:  q_d = {q_q[N-2:0], lsb_in_i};
      SelLoad:  q_d = d_i;
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Full-duplex serial shift sequencer. Accepts a word, parallel-loads it into
// a universal shift register, shifts one bit every DIV clocks while capturing
// serial_in, then offers the received word.
//   clk, reset : clock, async active-high reset
//   bus        : handshakes, abort, serial pins and status (slave modport)
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  shift_seq_ctrl_if.slave  bus
);

  localparam int unsigned BitW = $clog2(N);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(N - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  state_e          state_q, state_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            dir_q, dir_d;
  logic [N-1:0]    hold_q, hold_d;

  logic [1:0]      sel;
  logic [N-1:0]    q;
  logic            in_ready, serial_out, shift_tick, busy, out_valid;

  univ_shift_reg #(
    .N (N)
  ) u_shift_reg (
    .clk_i    (clk),
    .rst_ni   (~reset),
    .s_i      (sel),
    .d_i      (hold_q),
    .msb_in_i (bus.serial_in),
    .lsb_in_i (bus.serial_in),
    .q_o      (q)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    dir_d      = dir_q;
    hold_d     = hold_q;
    sel        = SelHold;
    in_ready   = 1'b0;
    serial_out = 1'b0;
    shift_tick = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          dir_d   = bus.dir;
          hold_d  = bus.in_data;
          state_d = StLoad;
        end
      end
      StLoad: begin
        busy      = 1'b1;
        sel       = SelLoad;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        busy       = 1'b1;
        serial_out = dir_q ? q[N-1] : q[0];
        if (div_cnt_q == DivLast) begin
          shift_tick = 1'b1;
          sel        = shift_sel(dir_q);
          div_cnt_d  = '0;
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = StDone;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything: no acceptance, no shift, register untouched.
    if (bus.abort) begin
      state_d    = StIdle;
      bit_cnt_d  = '0;
      div_cnt_d  = '0;
      dir_d      = dir_q;
      hold_d     = hold_q;
      sel        = SelHold;
      shift_tick = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      dir_q     <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      dir_q     <= dir_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.serial_out = serial_out;
  assign bus.shift_tick = shift_tick;
  assign bus.busy       = busy;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: one DIV=4 and one DIV=1 instance share stimulus;
// use_div1 selects which one is observed. Expected values come from the
// transfer rules: tick k lands k*DIV clocks after the load cycle, bit k sent
// is the k-th bit of the word in the chosen order, received bits fill the
// word from the far end.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       dir = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic       sin_v = 1'b0;
  logic       loop_en = 1'b0;
  logic       use_div1 = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  shift_seq_ctrl_if #(.N(8)) bus4 ();
  shift_seq_ctrl_if #(.N(8)) bus1 ();

  assign bus4.in_valid  = in_valid;
  assign bus4.in_data   = in_data;
  assign bus4.dir       = dir;
  assign bus4.abort     = abort;
  assign bus4.out_ready = out_ready;
  assign bus4.serial_in = loop_en ? bus4.serial_out : sin_v;

  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.dir       = dir;
  assign bus1.abort     = abort;
  assign bus1.out_ready = out_ready;
  assign bus1.serial_in = loop_en ? bus1.serial_out : sin_v;

  shift_seq_ctrl #(.N(8), .DIV(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
  shift_seq_ctrl #(.N(8), .DIV(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [7:0] o_in_ready, o_sout, o_tick, o_busy, o_valid, o_data;
  assign o_in_ready = {7'b0, use_div1 ? bus1.in_ready   : bus4.in_ready};
  assign o_sout     = {7'b0, use_div1 ? bus1.serial_out : bus4.serial_out};
  assign o_tick     = {7'b0, use_div1 ? bus1.shift_tick : bus4.shift_tick};
  assign o_busy     = {7'b0, use_div1 ? bus1.busy       : bus4.busy};
  assign o_valid    = {7'b0, use_div1 ? bus1.out_valid  : bus4.out_valid};
  assign o_data     = use_div1 ? bus1.out_data : bus4.out_data;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // mode: 0 random serial_in, 1 loopback, 2 tied 0, 3 tied 1.
  // abort_cyc: cycle after acceptance during which abort is held (0 = none).
  // hold: DONE cycles with out_ready low and in_valid high.
  task automatic xfer(input logic [7:0] w, input logic d, input int mode, input int div,
                      input int abort_cyc, input int hold);
    logic [7:0] exp_rx;
    logic       tx, rx;
    int         last;
    int         k;
    bit         aborted;
    exp_rx   = '0;
    last     = 1 + 8 * div;
    aborted  = 1'b0;
    use_div1 = (div == 1);
    loop_en  = (mode == 1);
    sin_v    = (mode == 3);
    @(negedge clk);
    check("idle_in_ready", o_in_ready, 8'd1);
    in_valid = 1'b1;
    in_data  = w;
    dir      = d;
    for (int cyc = 0; cyc <= last; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        dir      = 1'($urandom);
      end
      if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
        abort = 1'b0;
        check("abort_in_ready", o_in_ready, 8'd1);
        check("abort_busy", o_busy, 8'd0);
        for (int j = 0; j < 12; j++) begin
          check("abort_no_valid", o_valid, 8'd0);
          check("abort_no_tick", o_tick, 8'd0);
          @(negedge clk);
        end
        aborted = 1'b1;
        break;
      end
      k  = (cyc + div - 1) / div;
      tx = 1'b0;
      if (cyc == 0) begin
        check("load_busy", o_busy, 8'd1);
        check("load_in_ready", o_in_ready, 8'd0);
        check("load_tick", o_tick, 8'd0);
        check("load_sout", o_sout, 8'd0);
      end else if (cyc < last) begin
        tx = d ? w[8-k] : w[k-1];
        check("shift_busy", o_busy, 8'd1);
        check("shift_in_ready", o_in_ready, 8'd0);
        check("shift_valid", o_valid, 8'd0);
        check("shift_tick", o_tick, {7'b0, (cyc % div) == 0});
        check("shift_sout", o_sout, {7'b0, tx});
      end else begin
        check("done_valid", o_valid, 8'd1);
        check("done_data", o_data, exp_rx);
        check("done_busy", o_busy, 8'd0);
        check("done_in_ready", o_in_ready, 8'd0);
        check("done_tick", o_tick, 8'd0);
      end
      if (mode == 0) sin_v = 1'($urandom);
      if (cyc >= 1 && cyc < last && (cyc % div) == 0) begin
        rx = loop_en ? tx : sin_v;
        if (d) exp_rx[8-k] = rx;
        else   exp_rx[k-1] = rx;
      end
      if (abort_cyc != 0 && cyc == abort_cyc) abort = 1'b1;
    end
    if (!aborted) begin
      in_valid = (hold > 0);
      in_data  = 8'($urandom);
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        check("hold_valid", o_valid, 8'd1);
        check("hold_data", o_data, exp_rx);
        check("hold_in_ready", o_in_ready, 8'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_in_ready", o_in_ready, 8'd1);
      check("post_valid", o_valid, 8'd0);
    end
    loop_en = 1'b0;
  endtask

  initial begin
    // Reset values while reset is held.
    @(negedge clk);
    check("rst_in_ready", o_in_ready, 8'd1);
    check("rst_busy", o_busy, 8'd0);
    check("rst_valid", o_valid, 8'd0);
    check("rst_data", o_data, 8'd0);
    reset = 1'b0;

    // Asynchronous reset in the middle of shifting 8'hA5.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    dir      = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_in_ready", o_in_ready, 8'd1);
    check("arst_busy", o_busy, 8'd0);
    check("arst_valid", o_valid, 8'd0);
    check("arst_tick", o_tick, 8'd0);
    check("arst_sout", o_sout, 8'd0);
    check("arst_data", o_data, 8'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      check("arst_idle_ready", o_in_ready, 8'd1);
      check("arst_no_valid", o_valid, 8'd0);
    end

    xfer(8'hA5, 1'b0, 1, 4, 0, 0);   // LSB-first loopback
    xfer(8'h81, 1'b1, 2, 4, 0, 0);   // MSB-first, serial_in tied 0
    xfer(8'h5A, 1'b0, 3, 4, 0, 10);  // DONE held with in_valid high
    xfer(8'hC3, 1'b0, 0, 4, 13, 0);  // abort just after shift 3
    xfer(8'h3C, 1'b1, 1, 4, 0, 0);
    for (int i = 0; i < 6; i++) begin
      xfer(8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 4, 0,
           int'($urandom_range(0, 3)));
    end

    do_reset();
    xfer(8'hF0, 1'b0, 3, 1, 0, 0);   // DIV=1, serial_in tied 1
    for (int i = 0; i < 4; i++) begin
      xfer(8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1, 0,
           int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencing controller for an N-bit universal shift register used as a full-duplex serial shift engine. It accepts a parallel word over a valid/ready handshake, parallel-loads it, and shifts it out one bit every DIV clocks. Each shift also captures serial_in, so after N shifts the register holds the received word, which is presented over a second valid/ready handshake. It sits between a parallel producer/consumer and a serial pin pair.

Parameters:
N, 8, word width in bits (N >= 2)
DIV, 4, clocks per bit period (DIV >= 1); the shift event occurs on the last clock of each period

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  parallel word offered
in_ready  output  1  controller can accept a word (high only in IDLE)
in_data  input  N  word to transmit
dir  input  1  sampled with in_data: 0 = LSB-first (shift right), 1 = MSB-first (shift left)
abort  input  1  synchronous cancel, any state
serial_in  input  1  received serial bit
serial_out  output  1  transmitted serial bit
shift_tick  output  1  one-clock pulse on each shift event
busy  output  1  high in LOAD or SHIFT
out_valid  output  1  received word available (high only in DONE)
out_ready  input  1  consumer takes received word
out_data  output  N  received word (register contents)

Behaviour:
- One clock domain. Reset is asynchronous and active-high; clock port is clk, reset port is reset.
- Reset values: state IDLE, register 0, counters 0, dir_q 0.
- Reset outputs: in_ready=1, busy=0, out_valid=0, shift_tick=0, serial_out=0, out_data=0.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: in_ready=1 and register holds (s=00). On in_valid and in_ready: capture dir into dir_q and go to LOAD.
- LOAD, one cycle: drive s=11 with I=in_data, latched at acceptance. At the next edge the register loads, div_cnt=0, bit_cnt=0, and the FSM goes to SHIFT.
- in_data is captured into a holding register at acceptance, so the producer may change it afterwards.
- SHIFT, when div_cnt < DIV-1: s=00 and div_cnt increments.
- SHIFT, when div_cnt == DIV-1 (the shift event): shift_tick=1 and div_cnt wraps to 0.
  - dir_q=0: s=01, MSB_in=serial_in.
  - dir_q=1: s=10, LSB_in=serial_in.
  - bit_cnt increments. If bit_cnt == N-1, the FSM goes to DONE.
- serial_out in SHIFT is Q[0] when dir_q=0 and Q[N-1] when dir_q=1. It is 0 in every other state.
- serial_in is sampled only on shift-event edges.
- DONE: out_valid=1 and out_data=Q held stable. On out_ready, go to IDLE. out_valid stays high until the transfer completes.
- Latency: out_valid rises 1 + N*DIV clocks after the acceptance edge (33 for N=8, DIV=4). in_ready is low for 2 + N*DIV clocks per transaction minimum.
- Back-to-back: in_valid during DONE is not accepted (in_ready=0). The earliest new acceptance is the cycle after the DONE handshake.
- abort: highest priority after reset. The next state is IDLE from any state, counters clear, and out_valid is never asserted for the aborted word. The register contents are left as-is.
- abort together with in_valid in IDLE: the word is not accepted.
- DIV=1: a shift occurs every SHIFT cycle and shift_tick stays high for N consecutive cycles.
- Counter widths:
  - bit_cnt: $clog2(N) bits.
  - div_cnt: max(1, $clog2(DIV)) bits.
  - Both compare by equality. No wrap is possible beyond the terminal values.
- Reset mid-operation: immediate return to reset values with no output glitches beyond the async clear.

Decomposition:
- Shared package:
  - state enum (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3).
  - shift-select constants SEL_HOLD=2'b00, SEL_RIGHT=2'b01, SEL_LEFT=2'b10, SEL_LOAD=2'b11.
- Sub-module: one instance of univ_shift_reg (N passed through) as the datapath.
  - Its reset_n is driven from ~reset.
  - The controller owns only the FSM, counters, dir_q, the holding register and the output muxing.

Test Plan:
1. Reset mid-SHIFT with reset high for 1 clock asynchronously, while transmitting 8'hA5 -> all outputs at reset values immediately, in_ready=1 on release, no out_valid.
2. N=8, DIV=4, dir=0, in_data=8'hA5, serial_in looped to serial_out -> serial_out bits 1,0,1,0,0,1,0,1 at ticks 1..8, 8 shift_tick pulses 4 clocks apart, out_valid 33 clocks after acceptance, out_data=8'hA5.
3. dir=1, in_data=8'h81, serial_in tied 0 -> serial_out MSB-first 1,0,0,0,0,0,0,1, out_data=8'h00.
4. DONE with out_ready held low 10 clocks while in_valid=1 -> out_valid and out_data stable, in_ready=0, no acceptance; then out_ready=1 gives IDLE the next cycle and acceptance the cycle after.
5. abort asserted at shift 3 of 8 -> IDLE next clock, shift_tick stops, out_valid never rises, next word 8'h3C completes normally.
6. DIV=1, dir=0, in_data=8'hF0, serial_in=1 -> shift_tick high for 8 consecutive cycles, out_valid 9 clocks after acceptance, out_data=8'hFF.
